// File: rtl/pe_scatter_accumulator.sv
// Multi-lane PE reducer: per-lane products scatter-accumulated into a partial-sum buffer.
// Optional saturating accumulation is enabled with `define PE_ACC_SAT_EN.
module pe_scatter_accumulator #(
    parameter int LANES  = 3,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 10,
    parameter int ACC_W  = 36
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_start,
    input  logic                               i_valid,
    input  logic                               i_last,
    input  logic [LANES-1:0]                   i_lane_en,
    input  logic [LANES-1:0][ADDR_W-1:0]       i_addr,
    input  logic [LANES-1:0][DATA_W-1:0]       i_w,
    input  logic [LANES-1:0][DATA_W-1:0]       i_ia,
    output logic                               o_ready,
    output logic                               o_busy,
    output logic [DEPTH-1:0][ACC_W-1:0]        o_buf,
    output logic                               o_finish,
    output logic                               o_oor,
    output logic                               o_sat
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int PROD_W = 2 * DATA_W;
`ifdef PE_ACC_SAT_EN
    // Headroom so a colliding-lane sum never wraps before the clamp decision.
    localparam int SUM_W = ACC_W + LANES;
`else
    localparam int SUM_W = ACC_W;
`endif

    logic [1:0]                     state;
    logic [LANES-1:0]               lane_v;
    logic [LANES-1:0][ADDR_W-1:0]   lane_a;
    logic [LANES-1:0][PROD_W-1:0]   lane_p;
    logic [LANES-1:0]               in_range;
    logic                           accept;
    logic [DEPTH-1:0][SUM_W-1:0]    hit_sum;
    logic [DEPTH-1:0][ACC_W-1:0]    buf_next;

    assign accept   = (state == S_ACCUM) && i_valid;
    assign o_ready  = (state == S_ACCUM);
    assign o_busy   = (state == S_ACCUM) || (state == S_FLUSH);
    assign o_finish = (state == S_DONE);

    always_comb begin
        in_range = '0;
        for (int i = 0; i < LANES; i++) begin
            in_range[i] = 32'(i_addr[i]) < 32'(DEPTH);
        end
    end

    // Every lane hitting an entry contributes, so collisions merge in one beat.
    always_comb begin
        hit_sum = '0;
        for (int e = 0; e < DEPTH; e++) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_v[i] && (32'(lane_a[i]) == 32'(e))) begin
                    hit_sum[e] = hit_sum[e] + SUM_W'(lane_p[i]);
                end
            end
        end
    end

`ifdef PE_ACC_SAT_EN
    logic [DEPTH-1:0][SUM_W:0] wide_sum;
    logic [DEPTH-1:0]          clamp;

    always_comb begin
        wide_sum = '0;
        clamp    = '0;
        buf_next = '0;
        for (int e = 0; e < DEPTH; e++) begin
            wide_sum[e] = (SUM_W+1)'(o_buf[e]) + (SUM_W+1)'(hit_sum[e]);
            clamp[e]    = |wide_sum[e][SUM_W:ACC_W];
            buf_next[e] = clamp[e] ? {ACC_W{1'b1}} : wide_sum[e][ACC_W-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sat <= 1'b0;
        end else if (i_start) begin
            o_sat <= 1'b0;
        end else if (|clamp) begin
            o_sat <= 1'b1;
        end
    end
`else
    always_comb begin
        buf_next = '0;
        for (int e = 0; e < DEPTH; e++) begin
            buf_next[e] = o_buf[e] + hit_sum[e];
        end
    end

    assign o_sat = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            lane_v <= '0;
            lane_a <= '0;
            lane_p <= '0;
            o_buf  <= '0;
            o_oor  <= 1'b0;
        end else if (i_start) begin
            // Restart wins over everything, including the in-flight product.
            state  <= S_ACCUM;
            lane_v <= '0;
            o_buf  <= '0;
            o_oor  <= 1'b0;
        end else begin
            case (state)
                S_IDLE:  state <= S_IDLE;
                S_ACCUM: if (i_valid && i_last) state <= S_FLUSH;
                S_FLUSH: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            lane_v <= accept ? (i_lane_en & in_range) : '0;
            if (accept) begin
                lane_a <= i_addr;
                for (int i = 0; i < LANES; i++) begin
                    lane_p[i] <= PROD_W'(i_w[i]) * PROD_W'(i_ia[i]);
                end
                if (|(i_lane_en & ~in_range)) o_oor <= 1'b1;
            end
            o_buf <= buf_next;
        end
    end

endmodule
